vx_dram_arb: RTL and testbench

- Merges the icache and dcache DRAM request streams of one core into a single DRAM request port.
- Routes DRAM responses back to the originating cache.
- Sits directly downstream of the core memory unit's icache/dcache DRAM interfaces, upstream of the cluster L2/DRAM port.
- Round-robin arbitration; one registered output stage; source index appended to the tag.

---
 rtl/vx_dram_arb_pkg.sv | 15 +
 rtl/vx_dram_arb_if.sv | 62 ++++++
 rtl/vx_dram_arb_rr_arbiter.sv | 51 +++++
 rtl/vx_dram_arb.sv | 151 +++++++++++++++
 tb/tb_vx_dram_arb.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_dram_arb_pkg.sv
// Shared helpers for the DRAM request arbiter: width derivation for the
// source-index field appended to outgoing tags.
package vx_dram_arb_pkg;

    // Width of a source-index field; one input still gets a 1-bit field.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NUM_INPUTS   = 2;
    localparam int DEF_DATA_WIDTH   = 512;
    localparam int DEF_ADDR_WIDTH   = 26;
    localparam int DEF_TAG_IN_WIDTH = 28;

endpackage

// File: rtl/vx_dram_arb_if.sv
// Cache-side and DRAM-side request/response bundle of the DRAM arbiter.
// slave = arbiter view, master = environment (caches + DRAM) view.
interface vx_dram_arb_if
    import vx_dram_arb_pkg::*;
#(
    parameter int NUM_INPUTS   = DEF_NUM_INPUTS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int TAG_IN_WIDTH = DEF_TAG_IN_WIDTH
) ();
    localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8;
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + log2up(NUM_INPUTS);

    logic [NUM_INPUTS-1:0]              in_req_valid;
    logic [NUM_INPUTS-1:0]              in_req_rw;
    logic [NUM_INPUTS*BYTEEN_WIDTH-1:0] in_req_byteen;
    logic [NUM_INPUTS*ADDR_WIDTH-1:0]   in_req_addr;
    logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_req_data;
    logic [NUM_INPUTS*TAG_IN_WIDTH-1:0] in_req_tag;
    logic [NUM_INPUTS-1:0]              in_req_ready;

    logic [NUM_INPUTS-1:0]              in_rsp_valid;
    logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_rsp_data;
    logic [NUM_INPUTS*TAG_IN_WIDTH-1:0] in_rsp_tag;
    logic [NUM_INPUTS-1:0]              in_rsp_ready;

    logic                               dram_req_valid;
    logic                               dram_req_rw;
    logic [BYTEEN_WIDTH-1:0]            dram_req_byteen;
    logic [ADDR_WIDTH-1:0]              dram_req_addr;
    logic [DATA_WIDTH-1:0]              dram_req_data;
    logic [TAG_OUT_WIDTH-1:0]           dram_req_tag;
    logic                               dram_req_ready;

    logic                               dram_rsp_valid;
    logic [DATA_WIDTH-1:0]              dram_rsp_data;
    logic [TAG_OUT_WIDTH-1:0]           dram_rsp_tag;
    logic                               dram_rsp_ready;

    modport slave (
        input  in_req_valid, in_req_rw, in_req_byteen, in_req_addr, in_req_data, in_req_tag,
        output in_req_ready,
        output in_rsp_valid, in_rsp_data, in_rsp_tag,
        input  in_rsp_ready,
        output dram_req_valid, dram_req_rw, dram_req_byteen, dram_req_addr, dram_req_data, dram_req_tag,
        input  dram_req_ready,
        input  dram_rsp_valid, dram_rsp_data, dram_rsp_tag,
        output dram_rsp_ready
    );

    modport master (
        output in_req_valid, in_req_rw, in_req_byteen, in_req_addr, in_req_data, in_req_tag,
        input  in_req_ready,
        input  in_rsp_valid, in_rsp_data, in_rsp_tag,
        output in_rsp_ready,
        input  dram_req_valid, dram_req_rw, dram_req_byteen, dram_req_addr, dram_req_data, dram_req_tag,
        output dram_req_ready,
        output dram_rsp_valid, dram_rsp_data, dram_rsp_tag,
        input  dram_rsp_ready
    );

endinterface

// File: rtl/vx_dram_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after the
// pointer; the pointer moves past the winner only on an enabled grant.
module vx_dram_arb_rr_arbiter
    import vx_dram_arb_pkg::*;
#(
    parameter  int NUM_REQS  = 2,
    localparam int IDX_WIDTH = log2up(NUM_REQS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQS-1:0]  requests,
    input  logic                 enable,
    output logic [NUM_REQS-1:0]  grant_onehot,
    output logic [IDX_WIDTH-1:0] grant_index
);
    logic [IDX_WIDTH-1:0] ptr;
    logic [NUM_REQS-1:0]  rotated;
    logic                 found;
    int                   offset;
    int                   winner;

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves a value held, which would otherwise infer a latch.
    always_comb begin
        rotated = NUM_REQS'({requests, requests} >> ptr);
        found   = 1'b0;
        offset  = 0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = k;
            end
        end
        winner = int'(ptr) + offset;
        if (winner >= NUM_REQS) winner = winner - NUM_REQS;
        grant_index  = IDX_WIDTH'(winner);
        grant_onehot = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            grant_onehot[i] = found && (winner == i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (enable && found) begin
            ptr <= (winner == NUM_REQS - 1) ? '0 : grant_index + 1'b1;
        end
    end

endmodule

// File: rtl/vx_dram_arb.sv
// Merges per-cache DRAM request streams into one registered port and routes
// responses back by the source index carried in the tag LSBs.
// Optional performance counters: define DRAM_ARB_PERF_EN.
module vx_dram_arb
    import vx_dram_arb_pkg::*;
#(
    parameter int NUM_INPUTS   = DEF_NUM_INPUTS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int TAG_IN_WIDTH = DEF_TAG_IN_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    vx_dram_arb_if.slave            bus
`ifdef DRAM_ARB_PERF_EN
    ,
    output logic [63:0]             perf_stall_cycles,
    output logic [NUM_INPUTS*32-1:0] perf_grants
`endif
);
    localparam int SRC_WIDTH     = log2up(NUM_INPUTS);
    localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8;
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + SRC_WIDTH;

    logic                     load_en;
    logic                     arb_enable;
    logic                     fire;
    logic [NUM_INPUTS-1:0]    grant_onehot;
    logic [SRC_WIDTH-1:0]     grant_index;

    logic                     sel_rw;
    logic [BYTEEN_WIDTH-1:0]  sel_byteen;
    logic [ADDR_WIDTH-1:0]    sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [TAG_IN_WIDTH-1:0]  sel_tag;

    logic                     req_valid_q;
    logic                     req_rw_q;
    logic [BYTEEN_WIDTH-1:0]  req_byteen_q;
    logic [ADDR_WIDTH-1:0]    req_addr_q;
    logic [DATA_WIDTH-1:0]    req_data_q;
    logic [TAG_OUT_WIDTH-1:0] req_tag_q;

    // The output register can take a new request when empty or draining.
    assign load_en    = !req_valid_q || bus.dram_req_ready;
    assign arb_enable = load_en && !reset;
    assign fire       = arb_enable && (|grant_onehot);

    vx_dram_arb_rr_arbiter #(.NUM_REQS(NUM_INPUTS)) u_arbiter (
        .clk          (clk),
        .reset        (reset),
        .requests     (bus.in_req_valid),
        .enable       (arb_enable),
        .grant_onehot (grant_onehot),
        .grant_index  (grant_index)
    );

    assign bus.in_req_ready = arb_enable ? grant_onehot : '0;

    always_comb begin
        sel_rw     = 1'b0;
        sel_byteen = '0;
        sel_addr   = '0;
        sel_data   = '0;
        sel_tag    = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_onehot[i]) begin
                sel_rw     = bus.in_req_rw[i];
                sel_byteen = bus.in_req_byteen[i*BYTEEN_WIDTH +: BYTEEN_WIDTH];
                sel_addr   = bus.in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data   = bus.in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_tag    = bus.in_req_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid_q <= 1'b0;
        end else if (load_en) begin
            req_valid_q <= |grant_onehot;
        end
    end

    // NOTE: the payload register has no reset; it is only observed while
    // req_valid_q is set, so clearing the wide datapath buys nothing.
    always_ff @(posedge clk) begin
        if (fire) begin
            req_rw_q     <= sel_rw;
            req_byteen_q <= sel_byteen;
            req_addr_q   <= sel_addr;
            req_data_q   <= sel_data;
            req_tag_q    <= {sel_tag, grant_index};
        end
    end

    assign bus.dram_req_valid  = req_valid_q;
    assign bus.dram_req_rw     = req_rw_q;
    assign bus.dram_req_byteen = req_byteen_q;
    assign bus.dram_req_addr   = req_addr_q;
    assign bus.dram_req_data   = req_data_q;
    assign bus.dram_req_tag    = req_tag_q;

    logic [SRC_WIDTH-1:0]  rsp_sel;
    logic                  rsp_in_range;
    logic [NUM_INPUTS-1:0] rsp_valid_vec;
    logic                  rsp_ready;

    assign rsp_sel      = bus.dram_rsp_tag[SRC_WIDTH-1:0];
    assign rsp_in_range = int'(rsp_sel) < NUM_INPUTS;

    // A source index with no matching input is drained rather than stalling DRAM.
    always_comb begin
        rsp_valid_vec = '0;
        rsp_ready     = 1'b1;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (int'(rsp_sel) == i) begin
                rsp_valid_vec[i] = bus.dram_rsp_valid;
                rsp_ready        = bus.in_rsp_ready[i];
            end
        end
    end

    assign bus.in_rsp_valid   = rsp_valid_vec;
    assign bus.dram_rsp_ready = rsp_ready;
    assign bus.in_rsp_data    = {NUM_INPUTS{bus.dram_rsp_data}};
    assign bus.in_rsp_tag     = {NUM_INPUTS{bus.dram_rsp_tag[TAG_OUT_WIDTH-1:SRC_WIDTH]}};

    always_ff @(posedge clk) begin
        if (!reset && bus.dram_rsp_valid) begin
            assert (rsp_in_range);
        end
    end

`ifdef DRAM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_grants       <= '0;
        end else begin
            if (req_valid_q && !bus.dram_req_ready) begin
                perf_stall_cycles <= perf_stall_cycles + 64'd1;
            end
            if (fire) begin
                perf_grants[int'(grant_index)*32 +: 32] <= perf_grants[int'(grant_index)*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_dram_arb.sv
// Self-checking bench for vx_dram_arb: a transaction-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_vx_dram_arb;
    localparam int NI  = 2;
    localparam int DW  = 512;
    localparam int AW  = 26;
    localparam int TW  = 28;
    localparam int BW  = DW / 8;
    localparam int SW  = 1;
    localparam int TOW = TW + SW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_dram_arb_if #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW)) bus ();

`ifdef DRAM_ARB_PERF_EN
    logic [63:0]     perf_stall_cycles;
    logic [NI*32-1:0] perf_grants;
`endif

    vx_dram_arb #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DRAM_ARB_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_grants       (perf_grants)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [599:0] act, input logic [599:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: one pending outgoing request, a round-robin pointer.
    bit              m_valid;
    int              m_ptr;
    bit              m_rw;
    logic [BW-1:0]   m_byteen;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    logic [TOW-1:0]  m_tag;
    longint          m_stall;
    int              m_grants[NI];

    function automatic int rr_pick(input int ptr, input logic [NI-1:0] v);
        for (int k = 0; k < NI; k++) begin
            int idx = (ptr + k) % NI;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NI-1:0] exp_ready();
        logic [NI-1:0] r = '0;
        int g;
        if (reset) return '0;
        if (m_valid && !bus.dram_req_ready) return '0;
        g = rr_pick(m_ptr, bus.in_req_valid);
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        int g;
        longint t;
        if (reset) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            m_stall = 0;
            for (int i = 0; i < NI; i++) m_grants[i] = 0;
        end else begin
            if (m_valid && !bus.dram_req_ready) m_stall++;
            if (!m_valid || bus.dram_req_ready) begin
                g = rr_pick(m_ptr, bus.in_req_valid);
                m_valid = (g >= 0);
                if (g >= 0) begin
                    m_rw     = bus.in_req_rw[g];
                    m_byteen = bus.in_req_byteen[g*BW +: BW];
                    m_addr   = bus.in_req_addr[g*AW +: AW];
                    m_data   = bus.in_req_data[g*DW +: DW];
                    t        = longint'(bus.in_req_tag[g*TW +: TW]);
                    m_tag    = TOW'(t * (longint'(1) << SW) + g);
                    m_ptr    = (g + 1) % NI;
                    m_grants[g]++;
                end
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        int sel;
        logic [NI-1:0] ev;
        logic er;
        if (cmp_en) begin
            check("in_req_ready", bus.in_req_ready, exp_ready());
            check("dram_req_valid", bus.dram_req_valid, m_valid);
            if (m_valid) begin
                check("dram_req_rw", bus.dram_req_rw, m_rw);
                check("dram_req_byteen", bus.dram_req_byteen, m_byteen);
                check("dram_req_addr", bus.dram_req_addr, m_addr);
                check("dram_req_data", bus.dram_req_data, m_data);
                check("dram_req_tag", bus.dram_req_tag, m_tag);
            end
            sel = int'(bus.dram_rsp_tag) % (1 << SW);
            ev  = '0;
            er  = 1'b1;
            if (sel < NI) begin
                ev[sel] = bus.dram_rsp_valid;
                er      = bus.in_rsp_ready[sel];
            end
            check("in_rsp_valid", bus.in_rsp_valid, ev);
            check("dram_rsp_ready", bus.dram_rsp_ready, er);
            for (int i = 0; i < NI; i++) begin
                check("in_rsp_tag", bus.in_rsp_tag[i*TW +: TW], bus.dram_rsp_tag / (1 << SW));
                check("in_rsp_data", bus.in_rsp_data[i*DW +: DW], bus.dram_rsp_data);
            end
`ifdef DRAM_ARB_PERF_EN
            check("perf_stall_cycles", perf_stall_cycles, m_stall);
            for (int i = 0; i < NI; i++) begin
                check("perf_grants", perf_grants[i*32 +: 32], m_grants[i]);
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input int i, input bit v, input bit rw, input logic [AW-1:0] addr,
                            input logic [TW-1:0] tag, input logic [31:0] seed);
        bus.in_req_valid[i]            = v;
        bus.in_req_rw[i]               = rw;
        bus.in_req_addr[i*AW +: AW]    = addr;
        bus.in_req_tag[i*TW +: TW]     = tag;
        bus.in_req_data[i*DW +: DW]    = {16{seed}};
        bus.in_req_byteen[i*BW +: BW]  = {2{seed ^ 32'h5A5A_0F0F}};
    endtask

    initial begin
        reset              = 1'b1;
        bus.in_req_valid   = '0;
        bus.in_req_rw      = '0;
        bus.in_req_byteen  = '0;
        bus.in_req_addr    = '0;
        bus.in_req_data    = '0;
        bus.in_req_tag     = '0;
        bus.in_rsp_ready   = '0;
        bus.dram_req_ready = 1'b1;
        bus.dram_rsp_valid = 1'b0;
        bus.dram_rsp_data  = '0;
        bus.dram_rsp_tag   = '0;

        // Reset: requests pending, nothing accepted, output empty.
        drive_in(0, 1'b1, 1'b0, 26'h11, 28'h1, 32'hDEAD_0001);
        tick();
        cmp_en = 1'b1;
        #2 check("reset_in_req_ready", bus.in_req_ready, 2'b00);
        tick();
        check("reset_dram_req_valid", bus.dram_req_valid, 1'b0);
        reset = 1'b0;
        drive_in(0, 1'b0, 1'b0, '0, '0, 32'h0);

        // Single request from input 1.
        drive_in(1, 1'b1, 1'b1, 26'h00040, 28'h5, 32'hCAFE_0040);
        #2 check("single_ready", bus.in_req_ready, 2'b10);
        tick();
        drive_in(1, 1'b0, 1'b0, '0, '0, 32'h0);
        #2;
        check("single_valid", bus.dram_req_valid, 1'b1);
        check("single_addr", bus.dram_req_addr, 26'h00040);
        check("single_tag", bus.dram_req_tag, 29'hB);
        check("single_rw", bus.dram_req_rw, 1'b1);
        tick();

        // Both inputs continuously valid from reset: strict alternation.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive_in(0, 1'b1, 1'b0, AW'(26'h1000 + c), TW'(28'h10 + c), 32'hA000_0000 + c);
            drive_in(1, 1'b1, 1'b1, AW'(26'h2000 + c), TW'(28'h20 + c), 32'hB000_0000 + c);
            #2 check("alt_ready", bus.in_req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check("alt_valid", bus.dram_req_valid, 1'b1);
            check("alt_tag", bus.dram_req_tag,
                  (c % 2 == 0) ? TOW'((28'h10 + c) * 2) : TOW'((28'h20 + c) * 2 + 1));
        end
        drive_in(0, 1'b0, 1'b0, '0, '0, 32'h0);
        drive_in(1, 1'b0, 1'b0, '0, '0, 32'h0);
        tick();

        // Stall: payload held, nothing accepted; on release input 1 wins.
        drive_in(0, 1'b1, 1'b0, 26'h100, 28'h7, 32'h1111_0100);
        tick();
        bus.dram_req_ready = 1'b0;
        drive_in(0, 1'b1, 1'b0, 26'h101, 28'h8, 32'h1111_0101);
        drive_in(1, 1'b1, 1'b0, 26'h200, 28'h9, 32'h2222_0200);
        for (int c = 0; c < 5; c++) begin
            #2;
            check("stall_ready", bus.in_req_ready, 2'b00);
            check("stall_addr", bus.dram_req_addr, 26'h100);
            tick();
        end
        bus.dram_req_ready = 1'b1;
        #2 check("release_ready", bus.in_req_ready, 2'b10);
        tick();
        check("release_addr", bus.dram_req_addr, 26'h200);
        check("release_tag", bus.dram_req_tag, 29'h13);
        drive_in(0, 1'b0, 1'b0, '0, '0, 32'h0);
        drive_in(1, 1'b0, 1'b0, '0, '0, 32'h0);
        tick();

        // Response routing by tag LSB.
        bus.dram_rsp_valid = 1'b1;
        bus.dram_rsp_tag   = 29'h6;
        bus.dram_rsp_data  = {16{32'h0BAD_F00D}};
        bus.in_rsp_ready   = 2'b00;
        #2;
        check("rsp_valid_sel0", bus.in_rsp_valid, 2'b01);
        check("rsp_ready_blocked", bus.dram_rsp_ready, 1'b0);
        tick();
        bus.in_rsp_ready = 2'b01;
        #2;
        check("rsp_ready_sel0", bus.dram_rsp_ready, 1'b1);
        check("rsp_tag0", bus.in_rsp_tag[TW-1:0], 28'h3);
        check("rsp_tag1", bus.in_rsp_tag[2*TW-1:TW], 28'h3);
        tick();
        bus.dram_rsp_tag = 29'h7;
        #2;
        check("rsp_valid_sel1", bus.in_rsp_valid, 2'b10);
        check("rsp_ready_sel1_low", bus.dram_rsp_ready, 1'b0);
        tick();
        bus.dram_rsp_valid = 1'b0;
        bus.in_rsp_ready   = 2'b00;
        tick();

        // Reset mid-transfer with pointer at 1: request dropped, input 0 first.
        drive_in(0, 1'b1, 1'b0, 26'h300, 28'hA, 32'h3333_0300);
        tick();
        drive_in(0, 1'b0, 1'b0, '0, '0, 32'h0);
        bus.dram_req_ready = 1'b0;
        tick();
        check("pre_reset_valid", bus.dram_req_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.dram_req_ready = 1'b1;
        check("post_reset_valid", bus.dram_req_valid, 1'b0);
        drive_in(0, 1'b1, 1'b0, 26'h400, 28'hC, 32'h4444_0400);
        drive_in(1, 1'b1, 1'b0, 26'h500, 28'hD, 32'h5555_0500);
        #2 check("post_reset_grant", bus.in_req_ready, 2'b01);
        tick();
        check("post_reset_tag", bus.dram_req_tag, 29'h18);
        drive_in(0, 1'b0, 1'b0, '0, '0, 32'h0);
        drive_in(1, 1'b0, 1'b0, '0, '0, 32'h0);
        tick();

`ifdef DRAM_ARB_PERF_EN
        // Counters: four grants to input 1, then three stalled cycles.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive_in(1, 1'b1, 1'b0, AW'(26'h600 + c), TW'(28'h30 + c), 32'h6666_0000 + c);
            tick();
        end
        drive_in(1, 1'b0, 1'b0, '0, '0, 32'h0);
        bus.dram_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        #2;
        check("perf_stall_literal", perf_stall_cycles, 64'd3);
        check("perf_grants1_literal", perf_grants[63:32], 32'd4);
        check("perf_grants0_literal", perf_grants[31:0], 32'd0);
        bus.dram_req_ready = 1'b1;
        tick();
        tick();
`endif

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
